// File: rtl/timer_sched.sv
//------------------------------------------------------------------------------
// timer_sched
//
// Runs a small table of timer intervals on an Avalon-style timer peripheral.
// Each step programs the timer period and control word, waits for the timer
// interrupt, clears it, reads the status back and checks that the IRQ bit
// actually cleared. Steps run in table order, once or looping, and the
// sequence can be aborted at any time. Aborts, timeouts and status errors all
// end with a write that stops the timer.
//
// Ports
//   CLOCK_50, reset_n        clock; asynchronous active-low reset
//   cfg_we, cfg_idx,         table write (accepted only while not busy)
//   cfg_period, cfg_prescale
//   cfg_count                number of table entries to run (1..DEPTH)
//   start, loop, abort       sequence control
//   busy, step_idx           sequencer status
//   step_done, seq_done, err one-cycle status pulses
//   t_*                      timer master bus: addr, write data/enable,
//                            read enable, chipselect, read data, irq
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module timer_sched #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 0
) (
   input  logic                     CLOCK_50,
   input  logic                     reset_n,
   input  logic                     cfg_we,
   input  logic [$clog2(DEPTH)-1:0] cfg_idx,
   input  logic [15:0]              cfg_period,
   input  logic [7:0]               cfg_prescale,
   input  logic [$clog2(DEPTH):0]   cfg_count,
   input  logic                     start,
   input  logic                     loop,
   input  logic                     abort,
   output logic                     busy,
   output logic [$clog2(DEPTH)-1:0] step_idx,
   output logic                     step_done,
   output logic                     seq_done,
   output logic                     err,
   output logic [1:0]               t_addr,
   output logic [15:0]              t_write_data,
   output logic                     t_write_en,
   output logic                     t_read_en,
   output logic                     t_chipselect,
   input  logic [15:0]              t_read_data,
   input  logic                     t_irq
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

   // Timer register map
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   typedef enum logic [2:0] {
      IDLE, WR_PER, WR_CTL, WAIT, ACK, RD_STAT, CHK, STOP
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  step_idx_q, step_idx_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              loop_q, loop_d;
   logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              rej_err_q, rej_err_d;
   logic              busy_q, busy_d;
   logic              cs_q, cs_d, we_q, we_d, re_q, re_d;
   logic [1:0]        addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [15:0]       period_q   [DEPTH];
   logic [15:0]       period_d   [DEPTH];
   logic [7:0]        prescale_q [DEPTH];
   logic [7:0]        prescale_d [DEPTH];

   logic              periods_ok, start_ok, last_step, to_err, chk_err;

   // Only the IRQ bit of the status word drives a decision.
   logic              unused_rd;
   assign unused_rd = ^{t_read_data[15:2], t_read_data[0]};

   // A start is legal only if every entry it will use has a nonzero period.
   always_comb begin
      periods_ok = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < cfg_count && period_q[i] == 16'h0000) periods_ok = 1'b0;
      end
      start_ok = (cfg_count != '0) && (cfg_count <= DEPTH_C) && periods_ok;
   end

   assign last_step = (CNT_W'(step_idx_q) + CNT_W'(1)) == count_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned; otherwise synthesis infers a latch.
      state_d    = state_q;
      step_idx_d = step_idx_q;
      count_d    = count_q;
      loop_d     = loop_q;
      wait_cnt_d = '0;
      rej_err_d  = 1'b0;
      period_d   = period_q;
      prescale_d = prescale_q;
      to_err     = 1'b0;
      chk_err    = 1'b0;
      step_done  = 1'b0;
      seq_done   = 1'b0;

      if (cfg_we && state_q == IDLE && CNT_W'(cfg_idx) < DEPTH_C) begin
         period_d[cfg_idx]   = cfg_period;
         prescale_d[cfg_idx] = cfg_prescale;
      end

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (start_ok) begin
                  count_d    = cfg_count;
                  loop_d     = loop;
                  step_idx_d = '0;
                  state_d    = WR_PER;
               end else begin
                  rej_err_d = 1'b1;
               end
            end
         end
         WR_PER:  state_d = WR_CTL;
         WR_CTL:  state_d = WAIT;
         WAIT: begin
            // An irq in the cycle the limit is reached still wins.
            if (t_irq) begin
               state_d = ACK;
            end else if (TIMEOUT > 0 && wait_cnt_q == TO_LIMIT) begin
               to_err  = 1'b1;
               state_d = STOP;
            end else begin
               wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
         end
         ACK:     state_d = RD_STAT;
         RD_STAT: state_d = CHK;
         CHK: begin
            // Read data is valid only in this cycle, so the step verdict is
            // decoded straight from the bus rather than registered.
            if (t_read_data[1]) begin
               chk_err = 1'b1;
               state_d = STOP;
            end else begin
               step_done = 1'b1;
               if (!last_step) begin
                  step_idx_d = step_idx_q + IDX_W'(1);
                  state_d    = WR_PER;
               end else if (loop_q) begin
                  step_idx_d = '0;
                  state_d    = WR_PER;
               end else begin
                  seq_done = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         STOP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort overrides whatever the state decided this cycle.
      if (abort && state_q != IDLE && state_q != STOP) begin
         state_d    = STOP;
         step_idx_d = step_idx_q;
         wait_cnt_d = '0;
         to_err     = 1'b0;
         chk_err    = 1'b0;
         step_done  = 1'b0;
         seq_done   = 1'b0;
      end

      err    = rej_err_q | to_err | chk_err;
      busy_d = (state_d != IDLE);

      // Bus outputs are registered from the next state so they line up with
      // the state that owns them.
      cs_d    = 1'b0;
      we_d    = 1'b0;
      re_d    = 1'b0;
      addr_d  = 2'd0;
      wdata_d = 16'h0000;
      case (state_d)
         WR_PER: begin
            cs_d = 1'b1; we_d = 1'b1; addr_d = REG_PERIOD;
            wdata_d = period_q[step_idx_d];
         end
         WR_CTL: begin
            // prescale, irq_en=1, reload=0, run=1
            cs_d = 1'b1; we_d = 1'b1; addr_d = REG_CTRL;
            wdata_d = {prescale_q[step_idx_d], 8'h05};
         end
         ACK: begin
            cs_d = 1'b1; we_d = 1'b1; addr_d = REG_STATUS;
            wdata_d = 16'h0002;
         end
         RD_STAT: begin
            cs_d = 1'b1; re_d = 1'b1; addr_d = REG_STATUS;
         end
         STOP: begin
            cs_d = 1'b1; we_d = 1'b1; addr_d = REG_CTRL;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         step_idx_q <= '0;
         count_q    <= '0;
         loop_q     <= 1'b0;
         wait_cnt_q <= '0;
         rej_err_q  <= 1'b0;
         busy_q     <= 1'b0;
         cs_q       <= 1'b0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         addr_q     <= 2'd0;
         wdata_q    <= 16'h0000;
         // NOTE: the table is small and a cleared table makes any start
         // after reset fail validation, so it is reset like ordinary state.
         for (int i = 0; i < DEPTH; i++) begin
            period_q[i]   <= 16'h0000;
            prescale_q[i] <= 8'h00;
         end
      end else begin
         // NOTE: non-blocking assignments keep every flop reading the values
         // from before the edge, independent of statement order.
         state_q    <= state_d;
         step_idx_q <= step_idx_d;
         count_q    <= count_d;
         loop_q     <= loop_d;
         wait_cnt_q <= wait_cnt_d;
         rej_err_q  <= rej_err_d;
         busy_q     <= busy_d;
         cs_q       <= cs_d;
         we_q       <= we_d;
         re_q       <= re_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         period_q   <= period_d;
         prescale_q <= prescale_d;
      end
   end

   assign busy         = busy_q;
   assign step_idx     = step_idx_q;
   assign t_chipselect = cs_q;
   assign t_write_en   = we_q;
   assign t_read_en    = re_q;
   assign t_addr       = addr_q;
   assign t_write_data = wdata_q;

endmodule
